// File: rtl/jtsdram_pkg.sv
// Shared types and constants for the jtsdram responder.
package jtsdram_pkg;

  // Responder FSM states
  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StWait,
    StData,
    StRfsh
  } state_e;

  // Requester that owns the current transaction
  typedef enum logic [2:0] {
    SrcProg,
    SrcBa0,
    SrcBa1,
    SrcBa2,
    SrcBa3
  } src_e;

  // Byte mask bit positions; a set bit leaves that byte untouched
  localparam int unsigned MaskLo = 0;
  localparam int unsigned MaskHi = 1;

  localparam int unsigned NumBanks = 4;

  // Shared latency / refresh down-counter width
  localparam int unsigned CntW = 8;

  // Map a bank number to its source code
  function automatic src_e bank_src(input logic [1:0] ba);
    src_e s;
    unique case (ba)
      2'd0:    s = SrcBa0;
      2'd1:    s = SrcBa1;
      2'd2:    s = SrcBa2;
      default: s = SrcBa3;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/jtsdram_rr_arb.sv
// Four-way round-robin arbiter. The search starts at the pointer; the pointer
// moves to winner+1 only when the caller commits a grant with advance.
module jtsdram_rr_arb
  import jtsdram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       advance,
  output logic [3:0] gnt,
  output logic [1:0] index
);

  logic [1:0] ptr_q;

  // First requester at or after the pointer wins
  always_comb begin
    logic       found;
    logic [1:0] cand;
    gnt   = '0;
    index = ptr_q;
    found = 1'b0;
    cand  = ptr_q;
    for (int i = 0; i < NumBanks; i++) begin
      cand = ptr_q + 2'(i);
      if (!found && req[cand]) begin
        found       = 1'b1;
        gnt[cand]   = 1'b1;
        index       = cand;
      end
    end
  end

  // Pointer rotates past the committed winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 2'd0;
    end else if (advance) begin
      ptr_q <= index + 2'd1;
    end
  end

endmodule

// File: rtl/jtsdram_resp.sv
// Responder end of the jtsdram bank/prog interface, backed by on-chip storage.
// Mimics the SDRAM controller's ack/rdy/data_read timing so the checker and
// sequencer can run without an SDRAM attached.
module jtsdram_resp
  import jtsdram_pkg::*;
#(
  parameter int unsigned AW       = 22,
  parameter int unsigned MEMW     = 10,
  parameter int unsigned LATENCY  = 4,
  parameter int unsigned RFSH_CYC = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  // prog port
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic [1:0]    prog_mask,
  input  logic [1:0]    prog_ba,
  input  logic          prog_we,
  input  logic          prog_rd,
  output logic          prog_ack,
  output logic          prog_rdy,
  // bank ports
  input  logic [AW-1:0] ba0_addr,
  input  logic [AW-1:0] ba1_addr,
  input  logic [AW-1:0] ba2_addr,
  input  logic [AW-1:0] ba3_addr,
  input  logic          ba0_rd,
  input  logic          ba1_rd,
  input  logic          ba2_rd,
  input  logic          ba3_rd,
  input  logic          ba0_wr,
  input  logic [15:0]   ba0_din,
  input  logic [1:0]    ba0_din_m,
  output logic          ba0_ack,
  output logic          ba1_ack,
  output logic          ba2_ack,
  output logic          ba3_ack,
  output logic          ba0_rdy,
  output logic          ba1_rdy,
  output logic          ba2_rdy,
  output logic          ba3_rdy,
  output logic [31:0]   data_read,
  input  logic          refresh_en
);

  localparam logic [CntW-1:0] LatLoad  = CntW'(LATENCY - 1);
  localparam logic [CntW-1:0] RfshLoad = CntW'(RFSH_CYC - 1);
  localparam int unsigned     Depth    = 2 ** MEMW;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  src_e              src_q;
  logic [1:0]        lat_ba_q;
  logic [MEMW-1:0]   lat_idx_q;
  logic [15:0]       lat_data_q;
  logic [1:0]        lat_mask_q;
  logic              lat_wr_q;
  logic              prog_ack_q, prog_rdy_q;
  logic [3:0]        ba_ack_q, ba_rdy_q;
  logic [31:0]       data_read_q;

  logic [3:0]        ba_req;
  logic [AW-1:0]     ba_addr [NumBanks];
  logic [3:0]        arb_gnt;
  logic [1:0]        arb_idx;
  logic              arb_adv;
  logic              prog_req;
  logic              mem_we;
  logic [MEMW-1:0]   idx_nxt;
  logic [15:0]       bank_lo [NumBanks];
  logic [15:0]       bank_hi [NumBanks];
  logic              unused_addr_bits;

  assign prog_req   = prog_we | prog_rd;
  assign ba_req     = {ba3_rd, ba2_rd, ba1_rd, ba0_rd | ba0_wr};
  assign ba_addr[0] = ba0_addr;
  assign ba_addr[1] = ba1_addr;
  assign ba_addr[2] = ba2_addr;
  assign ba_addr[3] = ba3_addr;

  // Upper address bits alias onto the same storage
  assign unused_addr_bits = ^{prog_addr[AW-1:MEMW], ba0_addr[AW-1:MEMW], ba1_addr[AW-1:MEMW],
                              ba2_addr[AW-1:MEMW], ba3_addr[AW-1:MEMW]};

  // Pointer moves only when a bank actually wins the IDLE decision
  assign arb_adv = (state_q == StIdle) && !refresh_en && !prog_req && (|ba_req);

  jtsdram_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (ba_req),
    .advance (arb_adv),
    .gnt     (arb_gnt),
    .index   (arb_idx)
  );

  // Second word of a read wraps inside the bank
  assign idx_nxt = lat_idx_q + {{(MEMW - 1){1'b0}}, 1'b1};
  assign mem_we  = (state_q == StGrant) && lat_wr_q;

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    logic [15:0] mem [Depth];

    // Byte-enable write, committed during the GRANT cycle
    always_ff @(posedge clk) begin
      if (mem_we && (lat_ba_q == 2'(b))) begin
        if (!lat_mask_q[MaskLo]) mem[lat_idx_q][7:0]  <= lat_data_q[7:0];
        if (!lat_mask_q[MaskHi]) mem[lat_idx_q][15:8] <= lat_data_q[15:8];
      end
    end

    assign bank_lo[b] = mem[lat_idx_q];
    assign bank_hi[b] = mem[idx_nxt];
  end

  // Main FSM; ack/rdy/data_read are registered so they line up with GRANT/DATA
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      src_q       <= SrcProg;
      lat_ba_q    <= 2'd0;
      lat_idx_q   <= '0;
      lat_data_q  <= '0;
      lat_mask_q  <= '0;
      lat_wr_q    <= 1'b0;
      prog_ack_q  <= 1'b0;
      prog_rdy_q  <= 1'b0;
      ba_ack_q    <= '0;
      ba_rdy_q    <= '0;
      data_read_q <= '0;
    end else begin
      prog_ack_q <= 1'b0;
      prog_rdy_q <= 1'b0;
      ba_ack_q   <= '0;
      ba_rdy_q   <= '0;
      unique case (state_q)
        StIdle: begin
          if (refresh_en) begin
            state_q <= StRfsh;
            cnt_q   <= RfshLoad;
          end else if (prog_req) begin
            state_q    <= StGrant;
            src_q      <= SrcProg;
            lat_ba_q   <= prog_ba;
            lat_idx_q  <= prog_addr[MEMW-1:0];
            lat_data_q <= prog_data;
            lat_mask_q <= prog_mask;
            lat_wr_q   <= prog_we;
            prog_ack_q <= 1'b1;
          end else if (|ba_req) begin
            state_q    <= StGrant;
            src_q      <= bank_src(arb_idx);
            lat_ba_q   <= arb_idx;
            lat_idx_q  <= ba_addr[arb_idx][MEMW-1:0];
            lat_data_q <= ba0_din;
            lat_mask_q <= ba0_din_m;
            lat_wr_q   <= (arb_idx == 2'd0) && ba0_wr;
            ba_ack_q   <= arb_gnt;
          end
        end
        StGrant: begin
          state_q <= StWait;
          cnt_q   <= LatLoad;
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_q <= StData;
            if (src_q == SrcProg) prog_rdy_q <= 1'b1;
            else                  ba_rdy_q[lat_ba_q] <= 1'b1;
            if (!lat_wr_q) data_read_q <= {bank_hi[lat_ba_q], bank_lo[lat_ba_q]};
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StData: begin
          state_q <= StIdle;
        end
        StRfsh: begin
          if (cnt_q == '0) state_q <= StIdle;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign prog_ack  = prog_ack_q;
  assign prog_rdy  = prog_rdy_q;
  assign ba0_ack   = ba_ack_q[0];
  assign ba1_ack   = ba_ack_q[1];
  assign ba2_ack   = ba_ack_q[2];
  assign ba3_ack   = ba_ack_q[3];
  assign ba0_rdy   = ba_rdy_q[0];
  assign ba1_rdy   = ba_rdy_q[1];
  assign ba2_rdy   = ba_rdy_q[2];
  assign ba3_rdy   = ba_rdy_q[3];
  assign data_read = data_read_q;

endmodule

// File: tb/tb_jtsdram_resp.sv
// Directed bench for jtsdram_resp: handshake timing, masking, wrap, arbitration,
// refresh hold-off and mid-transaction reset.
module tb_jtsdram_resp;

  localparam int AW       = 22;
  localparam int MEMW     = 10;
  localparam int LATENCY  = 4;
  localparam int RFSH_CYC = 8;
  localparam int SRC_PROG = 4;

  logic          clk, rst_n;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic [1:0]    prog_mask, prog_ba;
  logic          prog_we, prog_rd, prog_ack, prog_rdy;
  logic [AW-1:0] ba0_addr, ba1_addr, ba2_addr, ba3_addr;
  logic          ba0_rd, ba1_rd, ba2_rd, ba3_rd, ba0_wr;
  logic [15:0]   ba0_din;
  logic [1:0]    ba0_din_m;
  logic          ba0_ack, ba1_ack, ba2_ack, ba3_ack;
  logic          ba0_rdy, ba1_rdy, ba2_rdy, ba3_rdy;
  logic [31:0]   data_read;
  logic          refresh_en;

  int checks   = 0;
  int failures = 0;

  jtsdram_resp #(
    .AW       (AW),
    .MEMW     (MEMW),
    .LATENCY  (LATENCY),
    .RFSH_CYC (RFSH_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_mask  (prog_mask),
    .prog_ba    (prog_ba),
    .prog_we    (prog_we),
    .prog_rd    (prog_rd),
    .prog_ack   (prog_ack),
    .prog_rdy   (prog_rdy),
    .ba0_addr   (ba0_addr),
    .ba1_addr   (ba1_addr),
    .ba2_addr   (ba2_addr),
    .ba3_addr   (ba3_addr),
    .ba0_rd     (ba0_rd),
    .ba1_rd     (ba1_rd),
    .ba2_rd     (ba2_rd),
    .ba3_rd     (ba3_rd),
    .ba0_wr     (ba0_wr),
    .ba0_din    (ba0_din),
    .ba0_din_m  (ba0_din_m),
    .ba0_ack    (ba0_ack),
    .ba1_ack    (ba1_ack),
    .ba2_ack    (ba2_ack),
    .ba3_ack    (ba3_ack),
    .ba0_rdy    (ba0_rdy),
    .ba1_rdy    (ba1_rdy),
    .ba2_rdy    (ba2_rdy),
    .ba3_rdy    (ba3_rdy),
    .data_read  (data_read),
    .refresh_en (refresh_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ack(input int s);
    case (s)
      0:       return ba0_ack;
      1:       return ba1_ack;
      2:       return ba2_ack;
      3:       return ba3_ack;
      default: return prog_ack;
    endcase
  endfunction

  function automatic logic get_rdy(input int s);
    case (s)
      0:       return ba0_rdy;
      1:       return ba1_rdy;
      2:       return ba2_rdy;
      3:       return ba3_rdy;
      default: return prog_rdy;
    endcase
  endfunction

  function automatic logic [9:0] all_hs();
    return {prog_ack, ba3_ack, ba2_ack, ba1_ack, ba0_ack,
            prog_rdy, ba3_rdy, ba2_rdy, ba1_rdy, ba0_rdy};
  endfunction

  task automatic drive_req(input int s, input logic wr, input logic v);
    case (s)
      0:       if (wr) ba0_wr = v; else ba0_rd = v;
      1:       ba1_rd = v;
      2:       ba2_rd = v;
      3:       ba3_rd = v;
      default: if (wr) prog_we = v; else prog_rd = v;
    endcase
  endtask

  // One full request: raise, expect ack 1 cycle later, drop, expect rdy LATENCY+1 later
  task automatic xact(input string tag, input int s, input logic wr, input logic [1:0] ba,
                      input logic [AW-1:0] addr, input logic [15:0] din, input logic [1:0] mask);
    int n;
    @(negedge clk);
    case (s)
      0:       begin ba0_addr = addr; ba0_din = din; ba0_din_m = mask; end
      1:       ba1_addr = addr;
      2:       ba2_addr = addr;
      3:       ba3_addr = addr;
      default: begin prog_addr = addr; prog_ba = ba; prog_data = din; prog_mask = mask; end
    endcase
    drive_req(s, wr, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (!get_ack(s) && n < 20);
    check({tag, "_ack_lat"}, 32'(n), 32'd1);
    drive_req(s, wr, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!get_rdy(s) && n < 20);
    check({tag, "_rdy_lat"}, 32'(n), 32'(LATENCY + 1));
  endtask

  initial begin
    int n, acks, rdys, multi, idx, extra;
    logic [3:0] ackv;
    rst_n = 1'b0; refresh_en = 1'b0;
    prog_addr = '0; prog_data = '0; prog_mask = '0; prog_ba = '0; prog_we = 1'b0; prog_rd = 1'b0;
    ba0_addr = '0; ba1_addr = '0; ba2_addr = '0; ba3_addr = '0;
    ba0_rd = 1'b0; ba1_rd = 1'b0; ba2_rd = 1'b0; ba3_rd = 1'b0; ba0_wr = 1'b0;
    ba0_din = '0; ba0_din_m = '0;
    repeat (3) @(negedge clk);
    check("reset_hs", 32'(all_hs()), 32'd0);
    check("reset_data", data_read, 32'd0);
    rst_n = 1'b1;

    // prog write then read back
    xact("prog_wr", SRC_PROG, 1'b1, 2'd2, 22'd5, 16'hBEEF, 2'b00);
    check("prog_wr_keeps_data", data_read, 32'd0);
    xact("prog_rd", SRC_PROG, 1'b0, 2'd2, 22'd5, 16'h0000, 2'b00);
    check("prog_rd_lo", {16'h0, data_read[15:0]}, 32'h0000_BEEF);
    repeat (3) @(negedge clk);
    check("data_hold", {16'h0, data_read[15:0]}, 32'h0000_BEEF);

    // Upper address bits alias
    xact("alias", 2, 1'b0, 2'd2, 22'h3F_FC05, 16'h0000, 2'b00);
    check("alias_lo", {16'h0, data_read[15:0]}, 32'h0000_BEEF);

    // Index wrap within bank 1
    xact("w3ff", SRC_PROG, 1'b1, 2'd1, 22'h3FF, 16'h1234, 2'b00);
    xact("w000", SRC_PROG, 1'b1, 2'd1, 22'h000, 16'h5678, 2'b00);
    xact("wrap", 1, 1'b0, 2'd1, 22'h3FF, 16'h0000, 2'b00);
    check("wrap_data", data_read, 32'h5678_1234);

    // Byte masks through bank 0 and prog
    xact("m_full", 0, 1'b1, 2'd0, 22'd7, 16'hAAAA, 2'b00);
    xact("m_hi", 0, 1'b1, 2'd0, 22'd7, 16'h5555, 2'b10);
    xact("m_w8", 0, 1'b1, 2'd0, 22'd8, 16'h0F0F, 2'b00);
    xact("m_rd1", 0, 1'b0, 2'd0, 22'd7, 16'h0000, 2'b00);
    check("mask_hi_data", data_read, 32'h0F0F_AA55);
    xact("m_lo", SRC_PROG, 1'b1, 2'd0, 22'd8, 16'h1234, 2'b01);
    xact("m_rd2", 0, 1'b0, 2'd0, 22'd7, 16'h0000, 2'b00);
    check("mask_lo_data", data_read, 32'h120F_AA55);

    // Round-robin from reset: all four banks at once
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    ba0_addr = '0; ba1_addr = '0; ba2_addr = '0; ba3_addr = '0;
    ba0_rd = 1'b1; ba1_rd = 1'b1; ba2_rd = 1'b1; ba3_rd = 1'b1;
    acks = 0; rdys = 0; multi = 0; n = 0;
    while (rdys < 4 && n < 80) begin
      @(negedge clk); n++;
      ackv = {ba3_ack, ba2_ack, ba1_ack, ba0_ack};
      if ($countones(ackv) > 1) multi++;
      if (ba0_rdy | ba1_rdy | ba2_rdy | ba3_rdy) rdys++;
      if (ackv != 4'd0) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (ackv[i]) idx = i;
        check("rr_order", 32'(idx), 32'(acks));
        check("rr_rdy_before_ack", 32'(rdys), 32'(acks));
        acks++;
        drive_req(idx, 1'b0, 1'b0);
      end
    end
    check("rr_multi_ack", 32'(multi), 32'd0);
    check("rr_ack_count", 32'(acks), 32'd4);

    // Refresh holds off a pending bank 3 read
    @(negedge clk);
    refresh_en = 1'b1; ba3_addr = '0; ba3_rd = 1'b1;
    n = 0; extra = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) refresh_en = 1'b0;
      if (prog_ack | ba0_ack | ba1_ack | ba2_ack) extra++;
    end while (!ba3_ack && n < 30);
    check("rfsh_ack_lat", 32'(n), 32'(RFSH_CYC + 2));
    check("rfsh_other_acks", 32'(extra), 32'd0);
    ba3_rd = 1'b0;

    // Reset during WAIT aborts the read
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_in_reset", 32'(all_hs()), 32'd0);
    rst_n = 1'b1;
    check("abort_data", data_read, 32'd0);
    extra = 0;
    for (int i = 0; i < LATENCY + 6; i++) begin
      @(negedge clk);
      if (all_hs() != 10'd0) extra++;
    end
    check("abort_no_rdy", 32'(extra), 32'd0);
    check("abort_data_after", data_read, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
